// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants for the register-file write arbiter: default widths and requester ids.
package regfile_write_arbiter_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_IDX_W  = 5;
  localparam int unsigned DEF_DEPTH  = 2;
  localparam int unsigned NUM_REGS   = 32;

  localparam logic ROB_ID = 1'b0;
  localparam logic LSU_ID = 1'b1;

  // Round-robin: after a grant, favour the requester that was not granted.
  function automatic logic next_prio(input logic granted_id);
    return ~granted_id;
  endfunction

endpackage

// File: rtl/regfile_write_queue.sv
// Per-requester write FIFO; exposes head entry plus every slot's index/valid
// so the top can build the pending-register mask.
module write_queue
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned IDX_W  = DEF_IDX_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [IDX_W-1:0]       i_idx,
  input  logic [DATA_W-1:0]      i_data,
  input  logic                   i_pop,
  output logic                   o_ready_c,
  output logic                   o_empty_c,
  output logic [IDX_W-1:0]       o_head_idx_c,
  output logic [DATA_W-1:0]      o_head_data_c,
  output logic [DEPTH*IDX_W-1:0] o_entry_idx_c,
  output logic [DEPTH-1:0]       o_entry_vld
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [IDX_W-1:0]  r_idx  [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  // Ready depends only on registered occupancy, so a full queue never accepts.
  assign o_ready_c     = (r_count < CNT_W'(DEPTH));
  assign o_empty_c     = (r_count == '0);
  assign w_push        = i_push && o_ready_c;
  assign w_pop         = i_pop && !o_empty_c;
  assign o_head_idx_c  = r_idx[r_rd_ptr];
  assign o_head_data_c = r_data[r_rd_ptr];

  always_comb begin
    o_entry_idx_c = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      o_entry_idx_c[i*IDX_W +: IDX_W] = r_idx[i];
    end
  end

  // Push and pop never touch the same slot: that needs count 0 or DEPTH,
  // where one of them is blocked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      o_entry_vld <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_idx[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_idx[r_wr_ptr]       <= i_idx;
        r_data[r_wr_ptr]      <= i_data;
        o_entry_vld[r_wr_ptr] <= 1'b1;
        r_wr_ptr              <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        o_entry_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr              <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges ROB commit writes and LSU load writebacks into one register-file
// write port with round-robin arbitration and a pending-register mask.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned IDX_W  = DEF_IDX_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                robValid,
  output logic                robReady,
  input  logic [IDX_W-1:0]    robIndex,
  input  logic [DATA_W-1:0]   robData,
  input  logic                lsuValid,
  output logic                lsuReady,
  input  logic [IDX_W-1:0]    lsuIndex,
  input  logic [DATA_W-1:0]   lsuData,
  output logic                wrEnable,
  output logic [IDX_W-1:0]    wrIndex,
  output logic [DATA_W-1:0]   wrData,
  output logic [NUM_REGS-1:0] pendingMask,
  output logic                grantLsu
);

  logic                   w_rob_empty;
  logic                   w_lsu_empty;
  logic [IDX_W-1:0]       w_rob_head_idx;
  logic [IDX_W-1:0]       w_lsu_head_idx;
  logic [DATA_W-1:0]      w_rob_head_data;
  logic [DATA_W-1:0]      w_lsu_head_data;
  logic [DEPTH*IDX_W-1:0] w_rob_entry_idx;
  logic [DEPTH*IDX_W-1:0] w_lsu_entry_idx;
  logic [DEPTH-1:0]       w_rob_entry_vld;
  logic [DEPTH-1:0]       w_lsu_entry_vld;
  logic                   w_any;
  logic                   w_grant_lsu;
  logic                   w_rob_pop;
  logic                   w_lsu_pop;
  logic [NUM_REGS-1:0]    w_pending;

  logic                   r_prio;
  logic                   r_wr_en;
  logic [IDX_W-1:0]       r_wr_idx;
  logic [DATA_W-1:0]      r_wr_data;
  logic                   r_grant_lsu;

  // Writes to x0 are handshaked but never enqueued.
  write_queue #(.DATA_W(DATA_W), .IDX_W(IDX_W), .DEPTH(DEPTH)) u_rob_q (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_push        (robValid && (robIndex != '0)),
    .i_idx         (robIndex),
    .i_data        (robData),
    .i_pop         (w_rob_pop),
    .o_ready_c     (robReady),
    .o_empty_c     (w_rob_empty),
    .o_head_idx_c  (w_rob_head_idx),
    .o_head_data_c (w_rob_head_data),
    .o_entry_idx_c (w_rob_entry_idx),
    .o_entry_vld   (w_rob_entry_vld)
  );

  write_queue #(.DATA_W(DATA_W), .IDX_W(IDX_W), .DEPTH(DEPTH)) u_lsu_q (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_push        (lsuValid && (lsuIndex != '0)),
    .i_idx         (lsuIndex),
    .i_data        (lsuData),
    .i_pop         (w_lsu_pop),
    .o_ready_c     (lsuReady),
    .o_empty_c     (w_lsu_empty),
    .o_head_idx_c  (w_lsu_head_idx),
    .o_head_data_c (w_lsu_head_data),
    .o_entry_idx_c (w_lsu_entry_idx),
    .o_entry_vld   (w_lsu_entry_vld)
  );

  // A lone non-empty queue wins regardless of the priority flag.
  assign w_any       = !w_rob_empty || !w_lsu_empty;
  assign w_grant_lsu = !w_lsu_empty && (w_rob_empty || (r_prio == LSU_ID));
  assign w_lsu_pop   = w_grant_lsu;
  assign w_rob_pop   = w_any && !w_grant_lsu;

  always_comb begin
    w_pending = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (w_rob_entry_vld[i]) w_pending[w_rob_entry_idx[i*IDX_W +: IDX_W]] = 1'b1;
      if (w_lsu_entry_vld[i]) w_pending[w_lsu_entry_idx[i*IDX_W +: IDX_W]] = 1'b1;
    end
    w_pending[0] = 1'b0;
  end

  // Index/data/source hold their last values while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio      <= ROB_ID;
      r_wr_en     <= 1'b0;
      r_wr_idx    <= '0;
      r_wr_data   <= '0;
      r_grant_lsu <= 1'b0;
    end else begin
      r_wr_en <= w_any;
      if (w_any) begin
        r_wr_idx    <= w_grant_lsu ? w_lsu_head_idx : w_rob_head_idx;
        r_wr_data   <= w_grant_lsu ? w_lsu_head_data : w_rob_head_data;
        r_grant_lsu <= w_grant_lsu;
        r_prio      <= next_prio(w_grant_lsu);
      end
    end
  end

  assign wrEnable    = r_wr_en;
  assign wrIndex     = r_wr_idx;
  assign wrData      = r_wr_data;
  assign grantLsu    = r_grant_lsu;
  assign pendingMask = w_pending;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench: queue/arbiter reference model feeding a write scoreboard,
// a table of per-cycle vectors, and directed multi-cycle sequences.
module tb_regfile_write_arbiter;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        robValid = 1'b0;
  logic        robReady;
  logic [4:0]  robIndex = '0;
  logic [31:0] robData = '0;
  logic        lsuValid = 1'b0;
  logic        lsuReady;
  logic [4:0]  lsuIndex = '0;
  logic [31:0] lsuData = '0;
  logic        wrEnable;
  logic [4:0]  wrIndex;
  logic [31:0] wrData;
  logic [31:0] pendingMask;
  logic        grantLsu;

  regfile_write_arbiter #(.DATA_W(32), .IDX_W(5), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .robValid    (robValid),
    .robReady    (robReady),
    .robIndex    (robIndex),
    .robData     (robData),
    .lsuValid    (lsuValid),
    .lsuReady    (lsuReady),
    .lsuIndex    (lsuIndex),
    .lsuData     (lsuData),
    .wrEnable    (wrEnable),
    .wrIndex     (wrIndex),
    .wrData      (wrData),
    .pendingMask (pendingMask),
    .grantLsu    (grantLsu)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: two FIFOs, a priority flag, and the write scoreboard.
  typedef struct packed { logic [4:0] idx; logic [31:0] data; } ent_t;
  typedef struct packed { logic [4:0] idx; logic [31:0] data; logic gl; } wr_t;

  ent_t m_rob[$];
  ent_t m_lsu[$];
  wr_t  sb[$];
  logic m_prio = 1'b0;

  task automatic model_clear();
    m_rob.delete();
    m_lsu.delete();
    sb.delete();
    m_prio = 1'b0;
  endtask

  task automatic model_step();
    ent_t e;
    wr_t  w;
    logic rob_rdy, lsu_rdy, gl;
    if (!rst_n) begin
      model_clear();
      return;
    end
    rob_rdy = (m_rob.size() < DEPTH);
    lsu_rdy = (m_lsu.size() < DEPTH);
    if (m_rob.size() > 0 || m_lsu.size() > 0) begin
      gl = (m_lsu.size() > 0) && ((m_rob.size() == 0) || m_prio);
      if (gl) e = m_lsu.pop_front();
      else    e = m_rob.pop_front();
      w.idx  = e.idx;
      w.data = e.data;
      w.gl   = gl;
      sb.push_back(w);
      m_prio = !gl;
    end
    if (robValid && rob_rdy && robIndex != 5'd0) begin
      e.idx = robIndex; e.data = robData; m_rob.push_back(e);
    end
    if (lsuValid && lsu_rdy && lsuIndex != 5'd0) begin
      e.idx = lsuIndex; e.data = lsuData; m_lsu.push_back(e);
    end
  endtask

  task automatic sb_check();
    wr_t         w;
    logic [31:0] pm;
    pm = '0;
    foreach (m_rob[i]) pm[m_rob[i].idx] = 1'b1;
    foreach (m_lsu[i]) pm[m_lsu[i].idx] = 1'b1;
    pm[0] = 1'b0;
    chk("sb_ready", {robReady, lsuReady}, {m_rob.size() < DEPTH, m_lsu.size() < DEPTH});
    chk("sb_pending", pendingMask, pm);
    if (sb.size() > 0) begin
      w = sb.pop_front();
      chk("sb_write", {wrEnable, wrIndex, wrData, grantLsu}, {1'b1, w.idx, w.data, w.gl});
    end else begin
      chk("sb_idle", wrEnable, 1'b0);
    end
  endtask

  initial forever begin @(posedge clk); model_step(); end
  initial forever begin @(negedge rst_n); model_clear(); end
  initial forever begin @(negedge clk); sb_check(); end

  typedef struct {
    logic        rst_n;
    logic        rv; logic [4:0] ri; logic [31:0] rd;
    logic        lv; logic [4:0] li; logic [31:0] ld;
    logic        e_en; logic [4:0] e_idx; logic [31:0] e_data; logic e_gl;
    logic        e_rr; logic e_lr; logic [31:0] e_pm;
  } vec_t;

  vec_t tbl[9];

  task automatic idle();
    robValid = 1'b0; robIndex = '0; robData = '0;
    lsuValid = 1'b0; lsuIndex = '0; lsuData = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int          rk, lk, pulses;
    logic        ra, la;

    tbl[0] = '{1'b1, 1'b1, 5'd5, 32'hAA, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h20};
    tbl[1] = '{1'b1, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 5'd5, 32'hAA, 1'b0, 1'b1, 1'b1, 32'h0};
    tbl[2] = '{1'b1, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 5'd5, 32'hAA, 1'b0, 1'b1, 1'b1, 32'h0};
    tbl[3] = '{1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h0};
    tbl[4] = '{1'b1, 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h18};
    tbl[5] = '{1'b1, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 5'd3, 32'h11, 1'b0, 1'b1, 1'b1, 32'h10};
    tbl[6] = '{1'b1, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 5'd4, 32'h22, 1'b1, 1'b1, 1'b1, 32'h0};
    tbl[7] = '{1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd4, 32'h22, 1'b1, 1'b1, 1'b1, 32'h0};
    tbl[8] = '{1'b1, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 5'd4, 32'h22, 1'b1, 1'b1, 1'b1, 32'h0};

    // Reset state
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {wrEnable, wrIndex, wrData, grantLsu, robReady, lsuReady, pendingMask},
        {1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'd0});
    rst_n = 1'b1;

    // Per-cycle vectors: single write, reset, simultaneous requests, x0 write
    for (int i = 0; i < 9; i++) begin
      rst_n    = tbl[i].rst_n;
      robValid = tbl[i].rv; robIndex = tbl[i].ri; robData = tbl[i].rd;
      lsuValid = tbl[i].lv; lsuIndex = tbl[i].li; lsuData = tbl[i].ld;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i),
          {wrEnable, wrIndex, wrData, grantLsu, robReady, lsuReady, pendingMask},
          {tbl[i].e_en, tbl[i].e_idx, tbl[i].e_data, tbl[i].e_gl, tbl[i].e_rr, tbl[i].e_lr, tbl[i].e_pm});
    end
    idle();

    // Both requesters streaming: LSU fills after two accepts, grants alternate
    rk = 0; lk = 0;
    for (int c = 1; c <= 10; c++) begin
      robValid = 1'b1; robIndex = 5'(10 + rk); robData = 32'h1000 + 32'(rk);
      lsuValid = 1'b1; lsuIndex = 5'(7 + lk);  lsuData = 32'h2000 + 32'(lk);
      ra = robReady; la = lsuReady;
      @(posedge clk);
      #1;
      if (ra) rk++;
      if (la) lk++;
      if (c == 2) chk("lsu_full_after_2", {lsuReady, 8'(lk)}, {1'b0, 8'd2});
      if (c == 3) chk("lsu_blocked_until_deq", 8'(lk), 8'd2);
      if (c == 4) chk("lsu_third_after_deq", 8'(lk), 8'd3);
      if (c >= 2) chk($sformatf("alternate_c%0d", c), {wrEnable, grantLsu}, {1'b1, 1'(c % 2)});
    end
    idle();
    repeat (5) @(posedge clk);
    #1;
    chk("drained", {wrEnable, pendingMask}, {1'b0, 32'd0});

    // Reset with two queued writes
    robValid = 1'b1; robIndex = 5'd12; robData = 32'hC;
    lsuValid = 1'b1; lsuIndex = 5'd13; lsuData = 32'hD;
    @(posedge clk);
    #1;
    robIndex = 5'd14; robData = 32'hE; lsuValid = 1'b0;
    @(posedge clk);
    #1;
    idle();
    chk("pre_rst_busy", {wrEnable, 8'($countones(pendingMask))}, {1'b1, 8'd2});
    rst_n = 1'b0;
    #1;
    chk("rst_async", {wrEnable, wrIndex, wrData, grantLsu, robReady, lsuReady, pendingMask},
        {1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'd0});
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      if (wrEnable) pulses++;
    end
    chk("no_write_after_rst", 8'(pulses), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
